// File: rtl/dvi_pkg.sv
// Shared widths for the DVI output path.
package dvi_pkg;

  parameter int unsigned X_POS_W = 10;
  parameter int unsigned Y_POS_W = 10;

endpackage

// File: rtl/video_timing_gen.sv
// Raster timing source: free-running pixel/line counters plus sync, data-enable and
// frame-start strobes delayed to line up with the image generator's registered RGB.
module video_timing_gen
  import dvi_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned PIPE_DELAY = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic [X_POS_W-1:0] x_o,
  output logic [Y_POS_W-1:0] y_o,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               de_o,
  output logic               frame_start_o
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned PIPE_W  = 4 * PIPE_DELAY;

  localparam logic [X_POS_W-1:0] XLast = X_POS_W'(H_TOTAL - 1);
  localparam logic [Y_POS_W-1:0] YLast = Y_POS_W'(V_TOTAL - 1);

  // Stage layout is {fs, de, vs, hs}; idle value carries the deasserted sync levels.
  localparam logic [3:0] StageIdle = {1'b0, 1'b0, ~V_SYNC_POL, ~H_SYNC_POL};

  if (((H_TOTAL - 1) >> X_POS_W) != 0) begin : g_bad_x_width
    $error("video_timing_gen: H_TOTAL-1 does not fit in X_POS_W");
  end
  if (((V_TOTAL - 1) >> Y_POS_W) != 0) begin : g_bad_y_width
    $error("video_timing_gen: V_TOTAL-1 does not fit in Y_POS_W");
  end
  if (PIPE_DELAY < 1 || PIPE_DELAY > 8) begin : g_bad_pipe_delay
    $error("video_timing_gen: PIPE_DELAY must be within 1..8");
  end

  logic [X_POS_W-1:0] x_q, x_d;
  logic [Y_POS_W-1:0] y_q, y_d;
  logic [3:0]         strobe;
  logic [PIPE_W-1:0]  pipe_q, pipe_d;
  logic               hs_act, vs_act, de, fs;

  always_comb begin
    x_d = x_q + 1'b1;
    y_d = y_q;
    if (x_q == XLast) begin
      x_d = '0;
      y_d = (y_q == YLast) ? '0 : y_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  always_comb begin
    de     = (32'(x_q) < H_ACTIVE) && (32'(y_q) < V_ACTIVE);
    hs_act = (32'(x_q) >= H_ACTIVE + H_FP) && (32'(x_q) < H_ACTIVE + H_FP + H_SYNC);
    // Vertical sync spans whole lines, so it depends on y only.
    vs_act = (32'(y_q) >= V_ACTIVE + V_FP) && (32'(y_q) < V_ACTIVE + V_FP + V_SYNC);
    fs     = (x_q == '0) && (y_q == '0);
    strobe = {fs, de, vs_act ? V_SYNC_POL : ~V_SYNC_POL, hs_act ? H_SYNC_POL : ~H_SYNC_POL};
  end

  // Newest stage sits in the low nibble; the shift drops the oldest off the top.
  always_comb begin
    pipe_d = (pipe_q << 4) | PIPE_W'(strobe);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_q <= {PIPE_DELAY{StageIdle}};
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign x_o = x_q;
  assign y_o = y_q;
  assign {frame_start_o, de_o, vsync_o, hsync_o} = pipe_q[PIPE_W-1 -: 4];

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: a shrunken raster on two instances
// (delay 2 active-low syncs, delay 1 active-high syncs) checked every clock.
module tb_video_timing_gen;
  import dvi_pkg::*;

  localparam int HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int VA = 10, VF = 2, VS = 3, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [X_POS_W-1:0] x_m, x_v;
  logic [Y_POS_W-1:0] y_m, y_v;
  logic hs_m, vs_m, de_m, fs_m;
  logic hs_v, vs_v, de_v, fs_v;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .PIPE_DELAY(2)
  ) dut (
    .clk_i(clk), .rst_i(rst), .x_o(x_m), .y_o(y_m),
    .hsync_o(hs_m), .vsync_o(vs_m), .de_o(de_m), .frame_start_o(fs_m)
  );

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .PIPE_DELAY(1)
  ) dut_v (
    .clk_i(clk), .rst_i(rst), .x_o(x_v), .y_o(y_v),
    .hsync_o(hs_v), .vsync_o(vs_v), .de_o(de_v), .frame_start_o(fs_v)
  );

  int n_checks = 0;
  int n_errors = 0;

  int mx, my, cyc;
  logic [3:0] exp_m_q[$];
  logic [3:0] exp_v_q[$];
  int first_fs_m, last_fs_m, first_fs_v, last_fs_v;
  int de_cnt_m, hs_cnt_m, vs_cnt_m, de_cnt_v, hs_cnt_v, vs_cnt_v;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected {fs, de, vsync, hsync} for raster position (x, y).
  function automatic logic [3:0] strobe(input int x, input int y, input bit hpol, input bit vpol);
    logic de, hs_on, vs_on, fs;
    de    = (x < HA) && (y < VA);
    hs_on = (x >= HA + HF) && (x < HA + HF + HS);
    vs_on = (y >= VA + VF) && (y < VA + VF + VS);
    fs    = (x == 0) && (y == 0);
    return {fs, de, vs_on ? vpol : ~vpol, hs_on ? hpol : ~hpol};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_m_x"}, 32'(x_m), 0);
    check_eq({tag, "_m_y"}, 32'(y_m), 0);
    check_eq({tag, "_m_strb"}, 32'({fs_m, de_m, vs_m, hs_m}), 32'h3);
    check_eq({tag, "_v_x"}, 32'(x_v), 0);
    check_eq({tag, "_v_strb"}, 32'({fs_v, de_v, vs_v, hs_v}), 32'h0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    mx = 0;
    my = 0;
    cyc = 0;
    exp_m_q.delete();
    exp_v_q.delete();
    // One stage of idle ahead of the delay-2 instance; the delay-1 instance needs none.
    exp_m_q.push_back(4'b0011);
    first_fs_m = -1; last_fs_m = -1; first_fs_v = -1; last_fs_v = -1;
    de_cnt_m = 0; hs_cnt_m = 0; vs_cnt_m = 0;
    de_cnt_v = 0; hs_cnt_v = 0; vs_cnt_v = 0;
    repeat (5) @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    rst = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    logic [3:0] em, ev;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      exp_m_q.push_back(strobe(mx, my, 1'b0, 1'b0));
      exp_v_q.push_back(strobe(mx, my, 1'b1, 1'b1));
      mx++;
      if (mx == HT) begin
        mx = 0;
        my++;
        if (my == VT) my = 0;
      end
      check_eq("m_x", 32'(x_m), 32'(mx));
      check_eq("m_y", 32'(y_m), 32'(my));
      check_eq("v_x", 32'(x_v), 32'(mx));
      check_eq("v_y", 32'(y_v), 32'(my));
      em = exp_m_q.pop_front();
      ev = exp_v_q.pop_front();
      check_eq("m_strobes", 32'({fs_m, de_m, vs_m, hs_m}), 32'(em));
      check_eq("v_strobes", 32'({fs_v, de_v, vs_v, hs_v}), 32'(ev));
      if (fs_m) begin
        if (first_fs_m < 0) first_fs_m = cyc;
        else check_eq("m_fs_period", 32'(cyc - last_fs_m), FRAME);
        last_fs_m = cyc;
      end
      if (fs_v) begin
        if (first_fs_v < 0) first_fs_v = cyc;
        else check_eq("v_fs_period", 32'(cyc - last_fs_v), FRAME);
        last_fs_v = cyc;
      end
      if (cyc >= 2 && cyc < 2 + FRAME) begin
        if (de_m) de_cnt_m++;
        if (!hs_m) hs_cnt_m++;
        if (!vs_m) vs_cnt_m++;
      end
      if (cyc >= 1 && cyc < 1 + FRAME) begin
        if (de_v) de_cnt_v++;
        if (hs_v) hs_cnt_v++;
        if (vs_v) vs_cnt_v++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    apply_reset();
    run_cycles(2 * FRAME + 40);
    check_eq("m_first_fs", 32'(first_fs_m), 2);
    check_eq("v_first_fs", 32'(first_fs_v), 1);
    check_eq("m_de_count", 32'(de_cnt_m), HA * VA);
    check_eq("m_hs_count", 32'(hs_cnt_m), HS * VT);
    check_eq("m_vs_count", 32'(vs_cnt_m), VS * HT);
    check_eq("v_de_count", 32'(de_cnt_v), HA * VA);
    check_eq("v_hs_count", 32'(hs_cnt_v), HS * VT);
    check_eq("v_vs_count", 32'(vs_cnt_v), VS * HT);

    // Park inside the delayed hsync pulse so the async reset visibly flips hsync.
    for (int g = 0; g < FRAME && !(mx == 24 && my == 5); g++) run_cycles(1);
    check_eq("reach_24_5", 32'(mx == 24 && my == 5), 1);
    check_eq("pre_rst_m_hs", 32'(hs_m), 0);
    check_eq("pre_rst_v_hs", 32'(hs_v), 1);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    apply_reset();
    run_cycles(3 * HT + 5);
    check_eq("m_first_fs_after_rst", 32'(first_fs_m), 2);
    check_eq("v_first_fs_after_rst", 32'(first_fs_v), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
